// File: rtl/unidade_controle_seq.sv
// Sequencing control unit for the multicycle datapath: latches an instruction on run,
// steps through T1..T3 and drives bus selects, write enables and ALU controls.
module unidade_controle_seq #(
    parameter int REG_ADDR_W = 3,
    parameter int OPC_W      = 3
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  run,
    input  logic [OPC_W+2*REG_ADDR_W-1:0]         instr,
    input  logic                                  g_zero,
    output logic [(2**REG_ADDR_W)-1:0]            r_out,
    output logic                                  imm_out,
    output logic                                  g_out,
    output logic [(2**REG_ADDR_W)-1:0]            r_en,
    output logic                                  a_en,
    output logic                                  g_en,
    output logic [1:0]                            alu_op,
    output logic                                  out_en,
    output logic                                  busy,
    output logic                                  done
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int IR_W     = OPC_W + 2*REG_ADDR_W;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_NAND = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_MVNZ = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_MV   = OPC_W'(7);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t                  state_q, state_d;
    logic [IR_W-1:0]         ir_q, ir_d;
    logic [OPC_W-1:0]        opc;
    logic [REG_ADDR_W-1:0]   rx, ry;
    logic                    last_step;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign opc = ir_q[IR_W-1 -: OPC_W];
    assign rx  = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry  = ir_q[REG_ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        r_out     = '0;
        imm_out   = 1'b0;
        g_out     = 1'b0;
        r_en      = '0;
        a_en      = 1'b0;
        g_en      = 1'b0;
        alu_op    = 2'b00;
        out_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    ir_d    = instr;
                    state_d = T1;
                end
            end
            T1: begin
                busy = 1'b1;
                case (opc)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        r_out   = onehot(rx);
                        a_en    = 1'b1;
                        state_d = T2;
                    end
                    OP_MVNZ: begin
                        r_out     = onehot(ry);
                        if (!g_zero) r_en = onehot(rx);
                        last_step = 1'b1;
                    end
                    OP_OUT: begin
                        r_out     = onehot(rx);
                        out_en    = 1'b1;
                        last_step = 1'b1;
                    end
                    OP_LDI: begin
                        imm_out   = 1'b1;
                        r_en      = onehot(rx);
                        last_step = 1'b1;
                    end
                    OP_MV: begin
                        r_out     = onehot(ry);
                        r_en      = onehot(rx);
                        last_step = 1'b1;
                    end
                    default: last_step = 1'b1;  // NOP
                endcase
            end
            T2: begin
                busy    = 1'b1;
                r_out   = onehot(ry);
                g_en    = 1'b1;
                state_d = T3;
                case (opc)
                    OP_SUB:  alu_op = 2'b01;
                    OP_NAND: alu_op = 2'b10;
                    default: alu_op = 2'b00;
                endcase
            end
            T3: begin
                busy      = 1'b1;
                g_out     = 1'b1;
                r_en      = onehot(rx);
                last_step = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The final step doubles as an accept slot so back-to-back issue has no bubble.
        if (last_step) begin
            done = 1'b1;
            if (run) begin
                ir_d    = instr;
                state_d = T1;
            end else begin
                state_d = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_unidade_controle_seq.sv
// Scoreboard bench: each scenario queues per-cycle stimulus with expected outputs, then replays and compares.
module tb_unidade_controle_seq;
    logic        clk = 1'b0;
    logic        rst, run, g_zero, run4;
    logic [8:0]  instr;
    logic [10:0] instr4;

    logic [7:0]  r_out, r_en;
    logic        imm_out, g_out, a_en, g_en, out_en, busy, done;
    logic [1:0]  alu_op;
    logic [15:0] r_out4, r_en4;
    logic        imm_out4, g_out4, a_en4, g_en4, out_en4, busy4, done4;
    logic [1:0]  alu_op4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        run;
        logic [8:0]  instr;
        logic        gz;
        logic        run4;
        logic [10:0] instr4;
    } stim_t;

    typedef struct {
        logic [24:0] e8;
        logic [40:0] e4;
        logic        chk4;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    unidade_controle_seq #(.REG_ADDR_W(3)) dut (
        .clk(clk), .resetn(rst), .run(run), .instr(instr), .g_zero(g_zero),
        .r_out(r_out), .imm_out(imm_out), .g_out(g_out), .r_en(r_en), .a_en(a_en),
        .g_en(g_en), .alu_op(alu_op), .out_en(out_en), .busy(busy), .done(done)
    );

    unidade_controle_seq #(.REG_ADDR_W(4)) dut4 (
        .clk(clk), .resetn(rst), .run(run4), .instr(instr4), .g_zero(g_zero),
        .r_out(r_out4), .imm_out(imm_out4), .g_out(g_out4), .r_en(r_en4), .a_en(a_en4),
        .g_en(g_en4), .alu_op(alu_op4), .out_en(out_en4), .busy(busy4), .done(done4)
    );

    // Expected-vector layout: {r_out, imm_out, g_out, r_en, a_en, g_en, alu_op, out_en, busy, done}
    function automatic logic [24:0] x8(input logic [7:0] ro, input logic im, input logic go,
                                       input logic [7:0] re, input logic a, input logic ge,
                                       input logic [1:0] op, input logic oe, input logic bz,
                                       input logic dn);
        return {ro, im, go, re, a, ge, op, oe, bz, dn};
    endfunction

    function automatic logic [40:0] x16(input logic [15:0] ro, input logic [15:0] re,
                                        input logic oe, input logic bz, input logic dn);
        return {ro, 1'b0, 1'b0, re, 1'b0, 1'b0, 2'b00, oe, bz, dn};
    endfunction

    task automatic push(input logic r, input logic rn, input logic [8:0] ins, input logic gz,
                        input logic [24:0] e8);
        stim_t s;
        exp_t  e;
        s = '{rst: r, run: rn, instr: ins, gz: gz, run4: 1'b0, instr4: 11'd0};
        e = '{e8: e8, e4: 41'd0, chk4: 1'b0};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push4(input logic r, input logic rn4, input logic [10:0] ins4,
                         input logic [40:0] e4);
        stim_t s;
        exp_t  e;
        s = '{rst: r, run: 1'b0, instr: 9'd0, gz: 1'b0, run4: rn4, instr4: ins4};
        e = '{e8: 25'd0, e4: e4, chk4: 1'b1};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus (called at posedge+1) and sample outputs at the falling edge.
    task automatic cycle(output logic [24:0] o8, output logic [40:0] o4, output exp_t e);
        stim_t s;
        s      = stim_q.pop_front();
        e      = exp_q.pop_front();
        rst    = s.rst;
        run    = s.run;
        instr  = s.instr;
        g_zero = s.gz;
        run4   = s.run4;
        instr4 = s.instr4;
        @(negedge clk);
        o8 = {r_out, imm_out, g_out, r_en, a_en, g_en, alu_op, out_en, busy, done};
        o4 = {r_out4, imm_out4, g_out4, r_en4, a_en4, g_en4, alu_op4, out_en4, busy4, done4};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        stim_t       s;
        exp_t        x;
        // Second reset cycle with run high, then release: nothing may have been accepted.
        s = '{rst: 1'b1, run: 1'b1, instr: 9'b000_001_010, gz: 1'b0, run4: 1'b1, instr4: 11'b100_1111_0000};
        x = '{e8: 25'd0, e4: 41'd0, chk4: 1'b1};
        stim_q.push_back(s); exp_q.push_back(x);
        s = '{rst: 1'b0, run: 1'b0, instr: 9'd0, gz: 1'b0, run4: 1'b0, instr4: 11'd0};
        stim_q.push_back(s); exp_q.push_back(x);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL reset cyc%0d dut8 got %h expected %h", n, o8, e.e8);
            end
            checks++;
            if (o4 !== e.e4) begin
                errors++;
                $display("FAIL reset cyc%0d dut16 got %h expected %h", n, o4, e.e4);
            end
            n++;
        end
    endtask

    task automatic test_add();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        // Run is held high through T1/T2 with a different instruction: must be ignored.
        push(0, 1, 9'b000_001_010, 0, 25'd0);
        push(0, 1, 9'b110_000_000, 0, x8(8'h02, 0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 0));
        push(0, 1, 9'b110_000_000, 0, x8(8'h04, 0, 0, 8'h00, 0, 1, 2'b00, 0, 1, 0));
        push(0, 0, 9'd0,           0, x8(8'h00, 0, 1, 8'h02, 0, 0, 2'b00, 0, 1, 1));
        push(0, 0, 9'd0,           0, 25'd0);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL add_r1_r2 cyc%0d got %h expected %h", n, o8, e.e8);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        // LDI r7 -> MV r0,r7 -> NAND r2,r2 -> OUT r3, run held on each done cycle.
        push(0, 1, 9'b101_111_000, 0, 25'd0);
        push(0, 1, 9'b111_000_111, 0, x8(8'h00, 1, 0, 8'h80, 0, 0, 2'b00, 0, 1, 1));
        push(0, 1, 9'b010_010_010, 0, x8(8'h80, 0, 0, 8'h01, 0, 0, 2'b00, 0, 1, 1));
        push(0, 0, 9'd0,           0, x8(8'h04, 0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 0));
        push(0, 0, 9'd0,           0, x8(8'h04, 0, 0, 8'h00, 0, 1, 2'b10, 0, 1, 0));
        push(0, 1, 9'b100_011_000, 0, x8(8'h00, 0, 1, 8'h04, 0, 0, 2'b00, 0, 1, 1));
        push(0, 0, 9'd0,           0, x8(8'h08, 0, 0, 8'h00, 0, 0, 2'b00, 1, 1, 1));
        push(0, 0, 9'd0,           0, 25'd0);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %h expected %h", n, o8, e.e8);
            end
            n++;
        end
    endtask

    task automatic test_mvnz_nop();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        push(0, 1, 9'b011_011_100, 1, 25'd0);
        push(0, 1, 9'b011_011_100, 1, x8(8'h10, 0, 0, 8'h00, 0, 0, 2'b00, 0, 1, 1));
        push(0, 1, 9'b110_000_000, 0, x8(8'h10, 0, 0, 8'h08, 0, 0, 2'b00, 0, 1, 1));
        push(0, 0, 9'd0,           0, x8(8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 1, 1));
        push(0, 0, 9'd0,           0, 25'd0);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL mvnz_nop cyc%0d got %h expected %h", n, o8, e.e8);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_sub();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        push(0, 1, 9'b001_101_110, 0, 25'd0);
        push(0, 0, 9'd0,           0, x8(8'h20, 0, 0, 8'h00, 1, 0, 2'b00, 0, 1, 0));
        push(1, 0, 9'd0,           0, x8(8'h40, 0, 0, 8'h00, 0, 1, 2'b01, 0, 1, 0));
        push(0, 0, 9'd0,           0, 25'd0);
        push(0, 0, 9'd0,           0, 25'd0);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL reset_mid_sub cyc%0d got %h expected %h", n, o8, e.e8);
            end
            n++;
        end
    endtask

    task automatic test_out16();
        logic [24:0] o8;
        logic [40:0] o4;
        exp_t        e;
        int          n;
        push4(0, 1, 11'b100_1111_0000, 41'd0);
        push4(0, 0, 11'd0,             x16(16'h8000, 16'h0000, 1, 1, 1));
        push4(0, 0, 11'd0,             41'd0);
        n = 0;
        while (stim_q.size() > 0) begin
            cycle(o8, o4, e);
            checks++;
            if (o4 !== e.e4) begin
                errors++;
                $display("FAIL out_r15_w4 cyc%0d got %h expected %h", n, o4, e.e4);
            end
            checks++;
            if (o8 !== e.e8) begin
                errors++;
                $display("FAIL out_r15_idle8 cyc%0d got %h expected %h", n, o8, e.e8);
            end
            n++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        run    = 1'b1;
        instr  = 9'b000_001_010;
        g_zero = 1'b0;
        run4   = 1'b1;
        instr4 = 11'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_mvnz_nop();
        test_reset_mid_sub();
        test_out16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
